nw_fill_controller: RTL and testbench

- Top-level sequencer for the Needleman-Wunsch score matrix store (Score_manager).
- Runs boundary initialisation of row 0 and column 0.
- Then walks every cell (i,j), 1..N, in row-major order: fetches diag/left/up, computes the cell score, writes it back.
- Sits between the sequence comparator, which supplies the match flag, and the score store. Pulses done when cell (N,N) is written.

---
 rtl/nw_fill_controller_if.sv | 36 +++
 rtl/nw_fill_controller.sv | 173 +++++++++++++++++
 tb/tb_nw_fill_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/nw_fill_controller_if.sv
// Bus between the Needleman-Wunsch fill sequencer, the score store and the comparator.
interface nw_fill_controller_if #(
   parameter int N       = 128,
   parameter int BitAddr = $clog2(N + 1)
);
   logic               start;
   logic               match;
   logic               signal;
   logic [8:0]         diag;
   logic [8:0]         left;
   logic [8:0]         up;
   logic               we;
   logic               en_init;
   logic               en_ins;
   logic               en_read;
   logic               en_counter_3;
   logic [BitAddr:0]   addr;
   logic [8:0]         data_in;
   logic [8:0]         max;
   logic [BitAddr:0]   i;
   logic [BitAddr:0]   j;
   logic               busy;
   logic               done;

   modport master (
      input  start, match, signal, diag, left, up,
      output we, en_init, en_ins, en_read, en_counter_3,
      output addr, data_in, max, i, j, busy, done
   );

   modport slave (
      output start, match, signal, diag, left, up,
      input  we, en_init, en_ins, en_read, en_counter_3,
      input  addr, data_in, max, i, j, busy, done
   );
endinterface

// File: rtl/nw_fill_controller.sv
// Sequencer for the NW score matrix: boundary init, then row-major cell fill.
module nw_fill_controller #(
   parameter int N        = 128,
   parameter int BitAddr  = $clog2(N + 1),
   parameter int MATCH    = 1,
   parameter int MISMATCH = -1,
   parameter int GAP      = -2
) (
   input logic                 clk,
   input logic                 rst,
   nw_fill_controller_if.master bus
);
   typedef enum logic [2:0] {IDLE, INIT, READ, WAIT, CALC, WRITE, DONE} state_t;

   localparam logic [BitAddr:0] LAST = (BitAddr + 1)'(N);
   localparam logic [BitAddr:0] ONE  = (BitAddr + 1)'(1);

   state_t           state_q, state_d;
   logic [BitAddr:0] k_q, k_d, i_q, i_d, j_q, j_d, addr_q, addr_d;
   logic             sub_q, sub_d;
   logic [8:0]       max_q, max_d, data_in_q, data_in_d;
   logic             we_q, we_d, en_init_q, en_init_d, en_ins_q, en_ins_d;
   logic             en_read_q, en_read_d, en_cnt_q, en_cnt_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic signed [10:0] d_s, u_s, l_s, best;
   logic [8:0]         best_sat;

   // Cell score: best of the three candidates, clamped to the 9-bit signed range.
   always_comb begin
      d_s  = 11'(signed'(bus.diag)) + 11'(bus.match ? MATCH : MISMATCH);
      u_s  = 11'(signed'(bus.up))   + 11'(GAP);
      l_s  = 11'(signed'(bus.left)) + 11'(GAP);
      best = d_s;
      if (u_s > best) best = u_s;
      if (l_s > best) best = l_s;
      if (best > 11'sd255)        best_sat = 9'h0FF;
      else if (best < -11'sd256)  best_sat = 9'h100;
      else                        best_sat = best[8:0];
   end

   // Next state and next registered outputs; outputs are derived from the state being entered.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      sub_d     = sub_q;
      i_d       = i_q;
      j_d       = j_q;
      max_d     = max_q;
      addr_d    = '0;
      data_in_d = '0;
      we_d      = 1'b0;
      en_init_d = 1'b0;
      en_ins_d  = 1'b0;
      en_read_d = 1'b0;
      en_cnt_d  = 1'b0;
      busy_d    = 1'b1;
      done_d    = 1'b0;

      case (state_q)
         IDLE: if (bus.start) begin
            state_d = INIT;
            k_d     = '0;
            sub_d   = 1'b0;
            i_d     = '0;
            j_d     = '0;
         end
         INIT: begin
            sub_d = ~sub_q;
            if (sub_q) begin
               if (k_q == LAST) begin
                  state_d = READ;
                  i_d     = ONE;
                  j_d     = ONE;
               end else begin
                  k_d = k_q + ONE;
               end
            end
         end
         READ:  if (bus.signal) state_d = WAIT;
         WAIT:  state_d = CALC;
         CALC: begin
            max_d   = best_sat;
            state_d = WRITE;
         end
         WRITE: begin
            if (j_q != LAST) begin
               j_d     = j_q + ONE;
               state_d = READ;
            end else if (i_q != LAST) begin
               j_d     = ONE;
               i_d     = i_q + ONE;
               state_d = READ;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         IDLE: busy_d = 1'b0;
         INIT: begin
            we_d      = 1'b1;
            en_init_d = 1'b1;
            addr_d    = k_d;
            data_in_d = 9'(int'(k_d) * GAP);
         end
         READ: begin
            en_read_d = 1'b1;
            en_cnt_d  = 1'b1;
         end
         WAIT:  en_read_d = 1'b1;
         WRITE: begin
            we_d     = 1'b1;
            en_ins_d = 1'b1;
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         sub_q     <= 1'b0;
         i_q       <= '0;
         j_q       <= '0;
         max_q     <= '0;
         addr_q    <= '0;
         data_in_q <= '0;
         we_q      <= 1'b0;
         en_init_q <= 1'b0;
         en_ins_q  <= 1'b0;
         en_read_q <= 1'b0;
         en_cnt_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         sub_q     <= sub_d;
         i_q       <= i_d;
         j_q       <= j_d;
         max_q     <= max_d;
         addr_q    <= addr_d;
         data_in_q <= data_in_d;
         we_q      <= we_d;
         en_init_q <= en_init_d;
         en_ins_q  <= en_ins_d;
         en_read_q <= en_read_d;
         en_cnt_q  <= en_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.we           = we_q;
   assign bus.en_init      = en_init_q;
   assign bus.en_ins       = en_ins_q;
   assign bus.en_read      = en_read_q;
   assign bus.en_counter_3 = en_cnt_q;
   assign bus.addr         = addr_q;
   assign bus.data_in      = data_in_q;
   assign bus.max          = max_q;
   assign bus.i            = i_q;
   assign bus.j            = j_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
endmodule

// File: tb/tb_nw_fill_controller.sv
// Directed bench for nw_fill_controller with N=4.
module tb_nw_fill_controller;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   rd_cnt = 0;

   always #5 clk = ~clk;

   nw_fill_controller_if #(.N(4)) bus ();

   nw_fill_controller #(.N(4), .MATCH(1), .MISMATCH(-1), .GAP(-2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; the store model raises signal on the third en_counter_3 cycle.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (bus.en_counter_3) begin
         rd_cnt++;
         bus.signal = (rd_cnt >= 3);
      end else begin
         rd_cnt     = 0;
         bus.signal = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"},      16'(bus.we), 16'd0);
      check({tag, "_en_init"}, 16'(bus.en_init), 16'd0);
      check({tag, "_en_ins"},  16'(bus.en_ins), 16'd0);
      check({tag, "_en_read"}, 16'(bus.en_read), 16'd0);
      check({tag, "_en_cnt"},  16'(bus.en_counter_3), 16'd0);
      check({tag, "_addr"},    16'(bus.addr), 16'd0);
      check({tag, "_data_in"}, 16'(bus.data_in), 16'd0);
      check({tag, "_max"},     16'(bus.max), 16'd0);
      check({tag, "_i"},       16'(bus.i), 16'd0);
      check({tag, "_j"},       16'(bus.j), 16'd0);
      check({tag, "_busy"},    16'(bus.busy), 16'd0);
      check({tag, "_done"},    16'(bus.done), 16'd0);
   endtask

   function automatic logic [8:0] ref_max(input logic [8:0] d, input logic [8:0] u,
                                          input logic [8:0] l, input logic m);
      int dv, uv, lv, mx;
      dv = int'($signed(d)) + (m ? 1 : -1);
      uv = int'($signed(u)) - 2;
      lv = int'($signed(l)) - 2;
      mx = dv;
      if (uv > mx) mx = uv;
      if (lv > mx) mx = lv;
      if (mx > 255)  mx = 255;
      if (mx < -256) mx = -256;
      return 9'(mx);
   endfunction

   // Entered in the first READ cycle of cell (ei,ej); leaves one cycle after WRITE.
   task automatic run_cell(input int ei, input int ej, input logic [8:0] d, input logic [8:0] u,
                           input logic [8:0] l, input logic m, input logic [8:0] exp_max);
      int n;
      check("cell_i", 16'(bus.i), 16'(ei));
      check("cell_j", 16'(bus.j), 16'(ej));
      check("cell_read", 16'(bus.en_read), 16'd1);
      bus.diag  = d;
      bus.up    = u;
      bus.left  = l;
      bus.match = m;
      for (n = 0; n < 20 && !bus.en_ins; n++) cycle();
      check("cell_latency", 16'(n), 16'd5);
      check("cell_max", 16'(bus.max), 16'(exp_max));
      check("cell_we", 16'(bus.we), 16'd1);
      check("cell_excl", 16'(bus.en_init), 16'd0);
      cycle();
      check("cell_ins_once", 16'(bus.en_ins), 16'd0);
   endtask

   task automatic gen_cell(input int ei, input int ej);
      int c;
      logic [8:0] d, u, l;
      logic m;
      c = (ei - 1) * 4 + (ej - 1);
      d = 9'(c * 37 - 200);
      u = 9'(c * 23 - 90);
      l = 9'(150 - c * 29);
      m = c[0];
      run_cell(ei, ej, d, u, l, m, ref_max(d, u, l, m));
   endtask

   initial begin
      logic [8:0] init_tab [5];
      init_tab = '{9'h000, 9'h1FE, 9'h1FC, 9'h1FA, 9'h1F8};
      bus.start = 1'b0;
      bus.match = 1'b0;
      bus.signal = 1'b0;
      bus.diag = '0;
      bus.left = '0;
      bus.up = '0;

      // Reset state
      cycle();
      cycle();
      check_all_zero("reset");
      rst = 1'b1;
      cycle();
      check("idle_busy", 16'(bus.busy), 16'd0);

      // Init ramp
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      for (int n = 0; n < 10; n++) begin
         check("init_we", 16'(bus.we), 16'd1);
         check("init_en", 16'(bus.en_init), 16'd1);
         check("init_addr", 16'(bus.addr), 16'(n / 2));
         check("init_data", 16'(bus.data_in), 16'(init_tab[n / 2]));
         check("init_ij", 16'({bus.i, bus.j}), 16'd0);
         check("init_busy", 16'(bus.busy), 16'd1);
         cycle();
      end
      check("read_cnt_en", 16'(bus.en_counter_3), 16'd1);
      check("read_no_init", 16'(bus.en_init), 16'd0);

      // Directed cells: match, mismatch, upper and lower saturation
      run_cell(1, 1, 9'h000, 9'h1FE, 9'h1FE, 1'b1, 9'h001);
      run_cell(1, 2, 9'h000, 9'h1FE, 9'h1FE, 1'b0, 9'h1FF);
      run_cell(1, 3, 9'h0FF, 9'h000, 9'h000, 1'b1, 9'h0FF);
      run_cell(1, 4, 9'h100, 9'h100, 9'h100, 1'b0, 9'h100);

      // Remaining sweep; start held high across row 2 must be ignored
      bus.start = 1'b1;
      for (int ej = 1; ej <= 4; ej++) gen_cell(2, ej);
      bus.start = 1'b0;
      for (int ei = 3; ei <= 4; ei++)
         for (int ej = 1; ej <= 4; ej++) gen_cell(ei, ej);

      check("done_pulse", 16'(bus.done), 16'd1);
      check("done_busy", 16'(bus.busy), 16'd1);
      check("done_no_we", 16'(bus.we), 16'd0);
      cycle();
      check("after_done", 16'(bus.done), 16'd0);
      check("after_busy", 16'(bus.busy), 16'd0);
      check("hold_i", 16'(bus.i), 16'd4);
      check("hold_j", 16'(bus.j), 16'd4);
      cycle();
      check("idle_stays", 16'(bus.busy), 16'd0);

      // Second run, reset at cell (2,3) READ
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      check("rerun_init", 16'(bus.en_init), 16'd1);
      for (int n = 0; n < 10; n++) cycle();
      for (int ej = 1; ej <= 4; ej++) gen_cell(1, ej);
      gen_cell(2, 1);
      gen_cell(2, 2);
      check("pre_rst_i", 16'(bus.i), 16'd2);
      check("pre_rst_j", 16'(bus.j), 16'd3);
      check("pre_rst_read", 16'(bus.en_read), 16'd1);
      rst = 1'b0;
      cycle();
      check_all_zero("midfill_rst");
      rst = 1'b1;
      cycle();
      check("post_rst_idle", 16'(bus.busy), 16'd0);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      check("restart_en_init", 16'(bus.en_init), 16'd1);
      check("restart_addr0", 16'(bus.addr), 16'd0);
      check("restart_data0", 16'(bus.data_in), 16'd0);
      check("restart_ij", 16'({bus.i, bus.j}), 16'd0);
      cycle();
      check("restart_sub1", 16'(bus.addr), 16'd0);
      cycle();
      check("restart_addr1", 16'(bus.addr), 16'd1);
      check("restart_data1", 16'(bus.data_in), 16'h1FE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
